// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_if
// Description : Bundles the fetch unit's signals: the instruction-memory
//               request/response channel, the decode-side instruction
//               handshake and the redirect input.
//               master = fetch unit side, slave = memory/pipeline side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifu_fetch_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch unit. Owns the fetch PC, keeps at most one
//               32-bit instruction read in flight, hands the fetched word and
//               its PC to decode, and flushes the stream on redirect.
//               Optional feature macro: IFU_PERF_CNT_EN adds the 64-bit
//               fetch_count output counting delivered instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
    input  wire logic   clk,
    input  wire logic   rst,
    ifu_fetch_if.master bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_drop;     // one stale response still owed by memory
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_inst_pc;

    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] w_pc_next;
    logic            w_unused_pc_lsb;

    // Redirect targets are forced to word alignment; the low bits are don't-care.
    assign w_redirect_pc   = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_pc_lsb = ^bus.redirect_pc[1:0];
    assign w_pc_next       = r_pc + XLEN'(4);

    // Outputs are decoded from registered state only, so no input reaches them combinationally.
    assign bus.imem_req_valid = (r_state == S_REQ);
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = (r_state == S_OUT);
    assign bus.inst           = r_inst;
    assign bus.inst_pc        = r_inst_pc;

    // Fetch sequencer: request, wait for the single response, present it, advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_drop    <= 1'b0;
            r_inst    <= c_nop;
            r_inst_pc <= '0;
        end else begin
            // A redirect always retargets the PC, whatever the state.
            if (bus.redirect_valid) begin
                r_pc <= w_redirect_pc;
            end
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    // The old request is still accepted if ready coincides with
                    // a redirect; its response must then be thrown away.
                    if (bus.imem_req_ready) begin
                        r_state <= S_WAIT;
                        r_drop  <= bus.redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (r_drop || bus.redirect_valid) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_inst    <= bus.imem_resp_data;
                            r_inst_pc <= r_pc;
                            r_state   <= S_OUT;
                        end
                    end else if (bus.redirect_valid) begin
                        r_drop <= 1'b1;
                    end
                end
                S_OUT: begin
                    // With a coincident redirect the PC already took the target above.
                    if (bus.redirect_valid) begin
                        r_state <= S_REQ;
                    end else if (bus.inst_ready) begin
                        r_pc    <= w_pc_next;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    // Count every delivered instruction, including one delivered alongside a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 64'd0;
        end else if (bus.inst_valid && bus.inst_ready) begin
            fetch_count <= fetch_count + 64'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Self-checking bench for ifu_fetch. A randomized memory and
//               pipeline model drive the unit; a program-order reference
//               (next PC = PC+4, or the redirect target) pushes expected
//               deliveries into a scoreboard that a separate monitor drains.
//               Honours IFU_PERF_CNT_EN for the fetch_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;
    localparam int          XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ifu_fetch_if #(.XLEN(XLEN)) bus ();
`ifdef IFU_PERF_CNT_EN
    logic [63:0] fetch_count;
`endif

    ifu_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus knobs (percentages / max extra latency)
    int p_rdy = 0, p_iready = 0, p_redir = 0, p_spur = 0, max_lat = 0;

    exp_t            exp_q[$];
    exp_t            mon_e;
    logic [63:0]     exp_pc = RESET_PC;
    longint unsigned n_hs = 0;
    logic            outstanding = 1'b0, late_pending = 1'b0;
    logic            prev_pend = 1'b0, prev_redir = 1'b0;
    logic [63:0]     out_addr = '0, prev_addr = '0;
    int              lat_cnt = 0;
    logic [63:0]     acc_q[$];
    int              acc_cyc[$];
    int              first_valid_cyc = -1;
    int              cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Instruction memory contents: the two documented words at the reset PC, a hash elsewhere.
    function automatic logic [31:0] memfn(input logic [63:0] a);
        if (a == RESET_PC)        return 32'h0010_0093;
        if (a == RESET_PC + 64'd4) return 32'h0020_0113;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0003;
    endfunction

    function automatic logic [63:0] pick_target();
        int unsigned r;
        r = $urandom_range(9);
        if (r == 0) return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
        if (r < 6)  return RESET_PC + 64'($urandom_range(4095));
        return {$urandom, $urandom};
    endfunction

    always @(posedge clk) cyc++;

    // Driver: memory model, pipeline model and program-order reference.
    always @(negedge clk) begin
        if (rst) begin
            bus.imem_req_ready  = 1'b0;
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
            bus.inst_ready      = 1'b0;
            bus.redirect_valid  = 1'b0;
            bus.redirect_pc     = '0;
            if (outstanding) late_pending = 1'b1;
            outstanding     = 1'b0;
            prev_pend       = 1'b0;
            prev_redir      = 1'b0;
            exp_q.delete();
            exp_pc          = RESET_PC;
            n_hs            = 0;
            acc_q.delete();
            acc_cyc.delete();
            first_valid_cyc = -1;
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
            if (outstanding) begin
                if (lat_cnt == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = memfn(out_addr);
                    outstanding         = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end else if (late_pending || ($urandom_range(99) < p_spur)) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = 32'hDEAD_BEEF;
                late_pending        = 1'b0;
            end

            if (prev_pend && !prev_redir) begin
                chk("req_hold_valid", bus.imem_req_valid, 1);
                chk("req_hold_addr", bus.imem_req_addr, prev_addr);
            end

            bus.imem_req_ready = ($urandom_range(99) < p_rdy);
            bus.inst_ready     = ($urandom_range(99) < p_iready);
            bus.redirect_valid = ($urandom_range(99) < p_redir);
            bus.redirect_pc    = pick_target();

            if (bus.imem_req_valid) begin
                chk("single_outstanding", outstanding, 0);
                chk("req_addr_aligned", bus.imem_req_addr[1:0], 0);
                if (bus.imem_req_ready) begin
                    outstanding = 1'b1;
                    out_addr    = bus.imem_req_addr;
                    lat_cnt     = $urandom_range(max_lat);
                    acc_q.push_back(bus.imem_req_addr);
                    acc_cyc.push_back(cyc);
                end
            end
            prev_pend  = bus.imem_req_valid && !bus.imem_req_ready;
            prev_addr  = bus.imem_req_addr;
            prev_redir = bus.redirect_valid;

            // Program order: a delivered instruction is the next sequential one;
            // a redirect (applied after any coincident delivery) restarts the stream.
            if (bus.inst_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (bus.inst_ready) begin
                    exp_q.push_back('{pc: exp_pc, ins: memfn(exp_pc)});
                    exp_pc = exp_pc + 64'd4;
                    n_hs++;
                end
            end
            if (bus.redirect_valid) exp_pc = bus.redirect_pc & ~64'h3;
        end
    end

    // Monitor: compare every delivered instruction against the scoreboard.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (bus.inst_valid && bus.inst_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_inst: got pc %h inst %h, expected no delivery", bus.inst_pc, bus.inst);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("inst_pc", bus.inst_pc, mon_e.pc);
                    chk("inst", {32'h0, bus.inst}, {32'h0, mon_e.ins});
                end
            end
`ifdef IFU_PERF_CNT_EN
            chk("fetch_count", fetch_count, n_hs - ((bus.inst_valid && bus.inst_ready) ? 1 : 0));
`endif
        end
    end

    task automatic check_reset_values();
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_inst_valid", bus.inst_valid, 0);
        chk("rst_inst", {32'h0, bus.inst}, {32'h0, NOP});
        chk("rst_inst_pc", bus.inst_pc, 0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_fetch_count", fetch_count, 0);
`endif
    endtask

    logic [31:0]     hold_inst;
    logic [63:0]     hold_pc;
    longint unsigned n0;
    int              waited;

    initial begin
        // Reset and its output values
        repeat (3) @(posedge clk);
        #2;
        check_reset_values();
        rst = 1'b0;

        // Memory backpressure: the first request must hold steady
        @(negedge clk);
        #2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            chk("bp_req_valid", bus.imem_req_valid, 1);
            chk("bp_req_addr", bus.imem_req_addr, RESET_PC);
        end

        // Full-speed sequential fetch with single-cycle memory
        p_rdy = 100;
        p_iready = 100;
        repeat (14) @(posedge clk);
        #2;
        chk("seq_accept_count_ge3", (acc_q.size() >= 3) ? 1 : 0, 1);
        if (acc_q.size() >= 3) begin
            chk("seq_addr0", acc_q[0], RESET_PC);
            chk("seq_addr1", acc_q[1], RESET_PC + 64'd4);
            chk("seq_addr2", acc_q[2], RESET_PC + 64'd8);
            chk("first_inst_latency", 64'(first_valid_cyc - acc_cyc[0]), 2);
            chk("next_req_latency", 64'(acc_cyc[1] - acc_cyc[0]), 3);
        end

        // Downstream stall: the presented instruction stays put, no new request
        p_iready = 0;
        waited = 0;
        while (!bus.inst_valid && waited < 40) begin
            @(negedge clk);
            #2;
            waited++;
        end
        chk("stall_reached_out", bus.inst_valid, 1);
        hold_inst = bus.inst;
        hold_pc   = bus.inst_pc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            chk("stall_valid", bus.inst_valid, 1);
            chk("stall_inst", {32'h0, bus.inst}, {32'h0, hold_inst});
            chk("stall_pc", bus.inst_pc, hold_pc);
            chk("stall_no_req", bus.imem_req_valid, 0);
        end
        p_iready = 100;

        // Randomized traffic with redirects, latency, backpressure and stray responses
        p_rdy = 70; p_iready = 70; p_redir = 8; p_spur = 5; max_lat = 3;
        repeat (4000) @(posedge clk);

        // Asynchronous reset while a response is pending
        waited = 0;
        @(posedge clk);
        #2;
        while (!outstanding && waited < 200) begin
            @(posedge clk);
            #2;
            waited++;
        end
        chk("reached_wait", outstanding, 1);
        rst = 1'b1;
        #1;
        check_reset_values();
        @(posedge clk);
        #2;
        rst = 1'b0;
        p_redir = 0; p_spur = 0; p_rdy = 100; p_iready = 100; max_lat = 0;
        repeat (10) @(posedge clk);
        #2;
        chk("restart_addr", (acc_q.size() > 0) ? acc_q[0] : 64'hX, RESET_PC);

        // More random traffic, then drain and confirm forward progress
        p_rdy = 60; p_iready = 60; p_redir = 10; p_spur = 5; max_lat = 2;
        repeat (2000) @(posedge clk);
        p_rdy = 100; p_iready = 100; p_redir = 0; p_spur = 0; max_lat = 0;
        repeat (4) @(posedge clk);
        n0 = n_hs;
        repeat (40) @(posedge clk);
        #2;
        chk("drain_progress", (n_hs - n0 >= 5) ? 1 : 0, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
`ifdef IFU_PERF_CNT_EN
        chk("final_fetch_count", fetch_count, n_hs);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit directly upstream of the single-cycle core.
- Owns the fetch PC and issues one 32-bit instruction read at a time to instruction memory over a valid/ready request and valid response channel.
- Presents the fetched instruction and its PC to the decode/execute stage over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) that flush any in-flight or buffered fetch.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000: fetch address after reset.
- XLEN, 64: PC/address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address, word aligned.
- imem_resp_valid  in  1  response data valid, one pulse per accepted request.
- imem_resp_data  in  32  fetched instruction word.
- inst_valid  out  1  inst/inst_pc valid to downstream.
- inst_ready  in  1  downstream consumes instruction.
- inst  out  32  instruction word.
- inst_pc  out  XLEN  PC of inst.
- redirect_valid  in  1  redirect fetch stream.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored, treated as 0.
- fetch_count  out  64  retired-fetch counter; only present when IFU_PERF_CNT_EN is defined.

Behaviour:
- Reset values (async, immediate):
  - state=IDLE, pc=RESET_PC, drop=0.
  - inst=32'h0000_0013 (NOP), inst_pc=0.
  - imem_req_valid=0, inst_valid=0.
- State machine, 4 states:
  - IDLE: first cycle after rst deasserts; goes to REQ unconditionally.
  - REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready, go to WAIT.
  - WAIT: awaiting response. At most one request is outstanding.
  - OUT: inst_valid=1. On inst_ready, pc<=pc+4 (mod 2^64) and go to REQ.
- imem_req_valid, imem_req_addr and inst_valid are decoded from the registered state/pc only; no combinational input-to-output paths.
- Response handling in WAIT:
  - drop=0: capture inst<=imem_resp_data and inst_pc<=pc, go to OUT.
  - drop=1: discard the data, clear drop, go to REQ.
- Best-case latency:
  - Request accepted in cycle N, response in N+1, inst_valid high in N+2.
  - inst_ready at N+2 gives the next request in N+3.
- Request stability: once asserted, imem_req_valid and imem_req_addr hold until accepted. The only exception is a redirect while still in REQ.
- Redirect (highest priority), pc<=redirect_pc & ~3 in every state:
  - IDLE: pc updated; go to REQ.
  - REQ, imem_req_ready=0: stay in REQ; the address changes to the redirect PC next cycle.
  - REQ, imem_req_ready=1: the old request is accepted anyway. Go to WAIT with drop=1.
  - WAIT, no response this cycle: drop<=1, stay in WAIT.
  - WAIT, response this cycle: discard the response, go to REQ.
  - OUT: inst_valid drops next cycle, go to REQ. If inst_ready is also high, that instruction counts as delivered, but pc takes redirect_pc, not pc+4.
- Back-to-back redirects: the last one wins; drop stays set until the single stale response is absorbed.
- Protocol errors: imem_resp_valid outside WAIT is ignored. Downstream may hold inst_ready high permanently.
- Reset mid-transaction:
  - State returns to IDLE immediately.
  - A response arriving after reset while in IDLE/REQ is ignored per the rule above.
  - The memory side must not deliver it into a new WAIT; this is the memory's responsibility.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- Defined:
  - 64-bit fetch_count increments once per inst_valid&&inst_ready handshake, including one coincident with a redirect.
  - Resets to 0 and wraps modulo 2^64.
- Undefined: the fetch_count port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then sequential fetch: imem returns 0x00100093, 0x00200113 with 1-cycle latency and inst_ready=1 -> first inst_valid 2 cycles after first request acceptance. inst_pc=0x80000000 then 0x80000004; request addresses 0x80000000, 0x80000004, 0x80000008.
- Memory backpressure: imem_req_ready=0 for 5 cycles -> imem_req_valid stays 1 and the address stays 0x80000000 throughout; exactly one request is accepted.
- Downstream stall: inst_ready=0 for 4 cycles in OUT -> inst and inst_pc stable, no new request; after inst_ready=1 the next request address is pc+4.
- Redirect during WAIT: redirect_pc=0x80001002 while waiting -> the stale response is dropped (inst_valid stays 0). The next request address is 0x80001000 and the delivered inst_pc is 0x80001000.
- Redirect coincident with inst handshake in OUT at pc 0x80000010, redirect_pc 0x80000100 -> the next request is 0x80000100, not 0x80000014. With IFU_PERF_CNT_EN defined, fetch_count increments by 1.
- Async reset asserted in WAIT -> outputs reset within the same cycle without a clock edge. A late imem_resp_valid is ignored; fetch restarts at RESET_PC.
